// File: rtl/shift_reg_pkg.sv
// Shared types for the universal shift register: mode encodings and helpers.
package shift_reg_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_SHL  = 3'b001,
    MODE_SHR  = 3'b010,
    MODE_LOAD = 3'b011,
    MODE_ROTL = 3'b100,
    MODE_ROTR = 3'b101
  } shift_mode_t;

  // Frame counter width: max(1, clog2(width)).
  function automatic int cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

  function automatic logic is_shift_op(input logic [2:0] m);
    return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROTL) || (m == MODE_ROTR);
  endfunction

endpackage

// File: rtl/shift_frame_cnt.sv
// Counts shifts modulo WIDTH; pulses frame_done the cycle after the wrapping shift.
module shift_frame_cnt
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       is_shift,
  input  logic                       is_load,
  output logic [cnt_w(WIDTH)-1:0]    cnt,
  output logic                       frame_done
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic wrap;
  assign wrap = en && is_shift && (cnt == LAST);

  // frame_done defaults low every cycle, so it is a single-cycle pulse by construction.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (en) begin
        if (is_load)       cnt <= '0;
        else if (is_shift) cnt <= wrap ? '0 : cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register: hold/shift/rotate/load with a frame counter.
// Optional: define SHIFT_REG_PARITY_EN to add the parity output (XOR of q).
module shift_reg_univ
  import shift_reg_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [2:0]              mode,
  input  logic                    sin_l,
  input  logic                    sin_r,
  input  logic [WIDTH-1:0]        pdata,
  output logic [WIDTH-1:0]        q,
  output logic                    sout_l,
  output logic                    sout_r,
  output logic [cnt_w(WIDTH)-1:0] cnt,
  output logic                    frame_done
`ifdef SHIFT_REG_PARITY_EN
  ,
  output logic                    parity
`endif
);

  logic [WIDTH-1:0] q_nxt;
  logic             is_shift, is_load;

  assign is_shift = is_shift_op(mode);
  assign is_load  = (mode == MODE_LOAD);

  // Undefined encodings (110, 111) fall to the default and hold.
  always_comb begin
    q_nxt = q;
    case (shift_mode_t'(mode))
      MODE_SHL:  q_nxt = {q[WIDTH-2:0], sin_l};
      MODE_SHR:  q_nxt = {sin_r, q[WIDTH-1:1]};
      MODE_LOAD: q_nxt = pdata;
      MODE_ROTL: q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROTR: q_nxt = {q[0], q[WIDTH-1:1]};
      default:   q_nxt = q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst)    q <= RST_VAL;
    else if (en) q <= q_nxt;
  end

  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];

`ifdef SHIFT_REG_PARITY_EN
  assign parity = ^q;
`endif

  shift_frame_cnt #(.WIDTH(WIDTH)) u_frame_cnt (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .is_shift   (is_shift),
    .is_load    (is_load),
    .cnt        (cnt),
    .frame_done (frame_done)
  );

endmodule

// File: doc/shift_reg_univ.md
SHIFT_REG_UNIV -- requirements
Module: shift_reg_univ

Interface
REQ-001 Parameter WIDTH, default 8: register width in bits; the block SHALL support any WIDTH >= 2.
REQ-002 Parameter RST_VAL, default 0: the WIDTH-bit value q SHALL take at reset.
REQ-003 clk  input  1  clock; all state SHALL update on the posedge of clk only.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 en  input  1  operation enable; when low, all state SHALL hold.
REQ-006 mode  input  3  operation select, encoded per REQ-012.
REQ-007 sin_l  input  1  serial input; it SHALL enter bit 0 on a left shift.
REQ-008 sin_r  input  1  serial input; it SHALL enter bit WIDTH-1 on a right shift.
REQ-009 pdata  input  WIDTH  parallel load data.
REQ-010 q  output  WIDTH  register contents; sout_l output 1 SHALL equal q[WIDTH-1]; sout_r output 1 SHALL equal q[0].
REQ-011 cnt  output  max(1,clog2(WIDTH))  shifts since the last load or wrap; frame_done  output  1  registered frame-complete pulse.

Function
REQ-012 mode encoding SHALL be: 000 HOLD, 001 SHL, 010 SHR, 011 LOAD, 100 ROTL, 101 ROTR; 110 and 111 SHALL behave as HOLD.
REQ-013 With rst=1 and en=1, q SHALL take its new value at the next posedge (latency 1): SHL {q[W-2:0],sin_l}; SHR {sin_r,q[W-1:1]}; ROTL {q[W-2:0],q[W-1]}; ROTR {q[0],q[W-1:1]}; LOAD pdata; HOLD q.
REQ-014 SHL, SHR, ROTL and ROTR SHALL count as shift operations; LOAD and HOLD SHALL NOT.
REQ-015 Each enabled shift operation SHALL increment cnt. The shift that brings the count to WIDTH SHALL set cnt to 0 and set frame_done=1 for exactly the following cycle.
REQ-016 An enabled LOAD SHALL set cnt to 0 and frame_done to 0, regardless of cnt's prior value.
REQ-017 frame_done SHALL be 0 in every cycle not covered by REQ-015, including cycles with en=0 and cycles after a HOLD.
REQ-018 With en=0, q and cnt SHALL hold regardless of mode, sin_l, sin_r and pdata.
REQ-019 Priority SHALL be: rst, then en, then mode.
REQ-020 Outputs sout_l and sout_r SHALL be combinational from q and SHALL carry no additional register.

Reset
REQ-021 On a posedge with rst=0, q SHALL become RST_VAL, cnt SHALL become 0 and frame_done SHALL become 0, independent of en and mode.
REQ-022 A reset asserted mid-frame SHALL discard the partial shift count; no frame_done SHALL follow the reset.

Configuration
REQ-023 When macro SHIFT_REG_PARITY_EN is defined, the block SHALL add output port parity (1 bit) equal to the XOR reduction of q (combinational from q).
REQ-024 When SHIFT_REG_PARITY_EN is undefined, the parity port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-025 Package shift_reg_pkg SHALL hold the mode encodings as the typedef shift_mode_t with named constants MODE_HOLD..MODE_ROTR.
REQ-026 The frame counter (cnt, wrap, frame_done) SHALL be a sub-module shift_frame_cnt with inputs clk, rst, en, is_shift and is_load.

Verification (WIDTH=8, RST_VAL=0)
REQ-027 rst=0 with en=1, mode=SHL, q=0xFF -> next cycle q=0x00, cnt=0, frame_done=0.
REQ-028 LOAD pdata=0xA5, then 3x SHL with sin_l=1 -> q=0x4B, 0x97, 0x2F in turn; cnt=3; sout_l=0.
REQ-029 LOAD 0x81, then 8x ROTR -> q=0x81 after the 8th; frame_done=1 for exactly one cycle after the 8th; cnt=0.
REQ-030 LOAD 0x01; en=0 with mode=SHR for 4 cycles -> q=0x01, cnt=0 throughout; then en=1, SHR with sin_r=1 -> q=0x80.
REQ-031 5x SHL, then LOAD 0x3C -> cnt=0; no frame_done until 8 further shifts complete.
REQ-032 With SHIFT_REG_PARITY_EN defined: LOAD 0x07 -> parity=1; one SHL with sin_l=0 -> q=0x0E, parity=1; LOAD 0x03 -> parity=0.
